// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle: ID-stage instruction fields, EX/MEM
// status, and the fence controls plus status returned to the pipeline.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  // ID-stage instruction fields
  logic [4:0]        rs1_d;
  logic [4:0]        rs2_d;
  logic              rs1_used_d;
  logic              rs2_used_d;
  logic [4:0]        rd_d;
  logic              reg_write_d;
  logic              mem_read_d;
  logic              mem_write_d;
  // EX / MEM status
  logic              branch_taken_e;
  logic              dmem_ready;
  // fence controls
  logic              StallIF;
  logic              StallID;
  logic              FlushD;
  logic              FlushE;
  logic              StallE;
  logic              StallM;
  logic              FlushW;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  // status
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d,
           mem_read_d, mem_write_d, branch_taken_e, dmem_ready,
    input  StallIF, StallID, FlushD, FlushE, StallE, StallM, FlushW,
           ForwardAE, ForwardBE, mem_timeout, stall_cycles
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_d, reg_write_d,
           mem_read_d, mem_write_d, branch_taken_e, dmem_ready,
    output StallIF, StallID, FlushD, FlushE, StallE, StallM, FlushW,
           ForwardAE, ForwardBE, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: load-use stalls, taken-branch
// flushes, data-memory wait freeze with sticky timeout, operand forwarding
// and a saturating stall-cycle counter. Fence controls are combinational
// from the local EX/MEM/WB shadows plus same-cycle inputs.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  typedef enum logic {RUN, MWAIT} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       mrd;
    logic       mwr;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_shadow_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       macc;
  } mem_shadow_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } wb_shadow_t;

  state_t            state;
  ex_shadow_t        exSh;
  mem_shadow_t       memSh;
  wb_shadow_t        wbSh;
  logic [7:0]        waitCnt;
  logic              timeoutQ;
  logic [PERF_W-1:0] stallCnt;

  logic       freeze;
  logic       loadUse;
  logic [7:0] waitNext;
  logic       stallIF, stallID, flushD, flushE, stallE, stallM, flushW;
  logic [1:0] fwdA, fwdB;

  // MEM result wins over WB result; x0 is never forwarded.
  function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                        input mem_shadow_t m,
                                        input wb_shadow_t w);
    if (m.we && m.rd != 5'd0 && m.rd == src)      return 2'b10;
    else if (w.we && w.rd != 5'd0 && w.rd == src) return 2'b01;
    else                                          return 2'b00;
  endfunction

  // Hazard detection and fence-control priority: freeze > branch > load-use.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    stallIF = 1'b0;
    stallID = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    flushW  = 1'b0;
    fwdA    = 2'b00;
    fwdB    = 2'b00;

    // The MEM shadow holds while waiting, so macc stays set through MWAIT.
    freeze  = (state == MWAIT || memSh.macc) && !hz.dmem_ready;
    loadUse = exSh.mrd && exSh.rd != 5'd0 &&
              ((hz.rs1_used_d && hz.rs1_d == exSh.rd) ||
               (hz.rs2_used_d && hz.rs2_d == exSh.rd));
    // The first frozen cycle counts as wait cycle 1.
    waitNext = (state == RUN) ? 8'd1 :
               (waitCnt == 8'hFF) ? 8'hFF : waitCnt + 8'd1;

    if (!rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else begin
      if (freeze) begin
        stallIF = 1'b1;
        stallID = 1'b1;
        stallE  = 1'b1;
        stallM  = 1'b1;
        flushW  = 1'b1;
      end else if (hz.branch_taken_e) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (loadUse) begin
        stallIF = 1'b1;
        stallID = 1'b1;
        flushE  = 1'b1;
      end
      fwdA = fwdSel(exSh.rs1, memSh, wbSh);
      fwdB = fwdSel(exSh.rs2, memSh, wbSh);
    end
  end

  // Shadow pipeline, wait FSM, timeout flag and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: all state here is a handful of flops, so every register is reset.
    if (!rst_n) begin
      state    <= RUN;
      exSh     <= '0;
      memSh    <= '0;
      wbSh     <= '0;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
      stallCnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so each shadow samples its pre-edge neighbour.
      if (stallM) begin
        wbSh <= '0;
      end else begin
        wbSh  <= '{rd: memSh.rd, we: memSh.we};
        memSh <= '{rd: exSh.rd, we: exSh.we, macc: exSh.mrd | exSh.mwr};
      end

      if (!stallE) begin
        if (flushE) begin
          exSh <= '0;
        end else begin
          exSh <= '{rd: hz.rd_d, we: hz.reg_write_d, mrd: hz.mem_read_d,
                    mwr: hz.mem_write_d, rs1: hz.rs1_d, rs2: hz.rs2_d};
        end
      end

      state <= freeze ? MWAIT : RUN;
      if (freeze) begin
        waitCnt <= waitNext;
        if (waitNext == TIMEOUT_CNT) timeoutQ <= 1'b1;
      end

      if (stallIF && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
    end
  end

  assign hz.StallIF      = stallIF;
  assign hz.StallID      = stallID;
  assign hz.FlushD       = flushD;
  assign hz.FlushE       = flushE;
  assign hz.StallE       = stallE;
  assign hz.StallM       = stallM;
  assign hz.FlushW       = flushW;
  assign hz.ForwardAE    = fwdA;
  assign hz.ForwardBE    = fwdB;
  assign hz.mem_timeout  = timeoutQ;
  assign hz.stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4, PERF_W=4 so the timeout
// and counter saturation are reachable in a few cycles).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(4)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .PERF_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  // Control vector order: {StallIF, StallID, FlushD, FlushE, StallE, StallM, FlushW}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LU     = 7'b1101000;
  localparam logic [6:0] C_BR     = 7'b0011000;
  localparam logic [6:0] C_FREEZE = 7'b1100111;

  function automatic logic [6:0] ctlNow();
    return {hz.StallIF, hz.StallID, hz.FlushD, hz.FlushE,
            hz.StallE, hz.StallM, hz.FlushW};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic we,
                       input logic mr, input logic mw);
    hz.rs1_d = r1; hz.rs1_used_d = u1;
    hz.rs2_d = r2; hz.rs2_used_d = u2;
    hz.rd_d = rd;  hz.reg_write_d = we;
    hz.mem_read_d = mr; hz.mem_write_d = mw;
  endtask

  task automatic clrId();
    setId(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clrId();
    hz.branch_taken_e = 1'b0;
    hz.dmem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  // Puts "lw x5" into the MEM shadow with an empty EX behind it.
  task automatic loadToMem();
    doReset();
    setId(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    clrId();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clrId();
    hz.branch_taken_e = 1'b1;
    hz.dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_BR) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctlNow(), C_BR);
    end
    checks++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got %b want 0000", {hz.ForwardAE, hz.ForwardBE});
    end
    tick();
    rst_n = 1'b1;
    hz.branch_taken_e = 1'b0;
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE || hz.stall_cycles !== 4'd0 || hz.mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_state: ctl %b cnt %0d to %b want 0 0 0",
                         ctlNow(), hz.stall_cycles, hz.mem_timeout);
    end
    tick();
  endtask

  task automatic test_load_use();
    doReset();
    setId(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE) begin
      errors++; $display("FAIL lu_idle: got %b want %b", ctlNow(), C_NONE);
    end
    tick();
    setId(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add x7,x5,x6
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_LU) begin
      errors++; $display("FAIL lu_stall: got %b want %b", ctlNow(), C_LU);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE) begin
      errors++; $display("FAIL lu_one_bubble: got %b want %b", ctlNow(), C_NONE);
    end
    tick();
    clrId();
    @(negedge clk);
    checks++;
    if (hz.ForwardAE !== 2'b01 || hz.ForwardBE !== 2'b00) begin
      errors++; $display("FAIL lu_fwd_wb: got A=%b B=%b want A=01 B=00", hz.ForwardAE, hz.ForwardBE);
    end
    checks++;
    if (hz.stall_cycles !== 4'd1) begin
      errors++; $display("FAIL lu_stall_cnt: got %0d want 1", hz.stall_cycles);
    end
    tick();
    // lw x0 followed by a reader of x0: no hazard
    doReset();
    setId(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    setId(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE) begin
      errors++; $display("FAIL lu_x0: got %b want %b", ctlNow(), C_NONE);
    end
    tick();
  endtask

  // Older writer rdOld, newer writer rdNew, then consumer reading s1/s2.
  task automatic fwdSeq(input string name, input logic [4:0] rdOld,
                        input logic [4:0] rdNew, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [1:0] expA,
                        input logic [1:0] expB);
    doReset();
    setId(5'd0, 1'b0, 5'd0, 1'b0, rdOld, 1'b1, 1'b0, 1'b0);
    tick();
    setId(5'd0, 1'b0, 5'd0, 1'b0, rdNew, 1'b1, 1'b0, 1'b0);
    tick();
    setId(s1, 1'b1, s2, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0);
    tick();
    clrId();
    @(negedge clk);
    checks++;
    if (hz.ForwardAE !== expA || hz.ForwardBE !== expB) begin
      errors++; $display("FAIL %s: got A=%b B=%b want A=%b B=%b",
                         name, hz.ForwardAE, hz.ForwardBE, expA, expB);
    end
    tick();
  endtask

  task automatic test_forward();
    fwdSeq("fwd_mem_prio", 5'd3, 5'd3, 5'd3, 5'd9, 2'b10, 2'b00);
    fwdSeq("fwd_wb_only",  5'd3, 5'd4, 5'd3, 5'd4, 2'b01, 2'b10);
    fwdSeq("fwd_x0",       5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00);
  endtask

  task automatic test_branch_vs_load_use();
    doReset();
    setId(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    tick();
    setId(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);   // lw x6,(x5)
    hz.branch_taken_e = 1'b1;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_BR) begin
      errors++; $display("FAIL br_lu_ctl: got %b want %b", ctlNow(), C_BR);
    end
    tick();
    hz.branch_taken_e = 1'b0;
    setId(5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);   // reader of x6
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE) begin
      errors++; $display("FAIL br_ex_empty: got %b want %b", ctlNow(), C_NONE);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    loadToMem();
    hz.dmem_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (ctlNow() !== C_FREEZE) begin
        errors++; $display("FAIL mw_freeze_%0d: got %b want %b", k, ctlNow(), C_FREEZE);
      end
      tick();
    end
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE) begin
      errors++; $display("FAIL mw_release: got %b want %b", ctlNow(), C_NONE);
    end
    tick();
    checks++;
    if (hz.stall_cycles !== 4'd3 || hz.mem_timeout !== 1'b0) begin
      errors++; $display("FAIL mw_counts: cnt %0d to %b want 3 0", hz.stall_cycles, hz.mem_timeout);
    end
  endtask

  task automatic test_timeout();
    loadToMem();
    hz.dmem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (hz.mem_timeout !== (k >= 5) || ctlNow() !== C_FREEZE) begin
        errors++; $display("FAIL to_wait_%0d: to %b ctl %b want %b %b",
                           k, hz.mem_timeout, ctlNow(), (k >= 5), C_FREEZE);
      end
      tick();
    end
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (hz.mem_timeout !== 1'b1 || ctlNow() !== C_NONE) begin
      errors++; $display("FAIL to_release: to %b ctl %b want 1 %b", hz.mem_timeout, ctlNow(), C_NONE);
    end
    tick();
    tick();
    checks++;
    if (hz.mem_timeout !== 1'b1 || hz.stall_cycles !== 4'd6) begin
      errors++; $display("FAIL to_sticky: to %b cnt %0d want 1 6", hz.mem_timeout, hz.stall_cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    loadToMem();
    hz.dmem_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (hz.mem_timeout !== 1'b1) begin
      errors++; $display("FAIL rmw_pre: to %b want 1", hz.mem_timeout);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_BR) begin
      errors++; $display("FAIL rmw_during: got %b want %b", ctlNow(), C_BR);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_NONE || hz.stall_cycles !== 4'd0 || hz.mem_timeout !== 1'b0) begin
      errors++; $display("FAIL rmw_after: ctl %b cnt %0d to %b want %b 0 0",
                         ctlNow(), hz.stall_cycles, hz.mem_timeout, C_NONE);
    end
    hz.dmem_ready = 1'b1;
    tick();
  endtask

  task automatic test_branch_release();
    loadToMem();
    hz.dmem_ready = 1'b0;
    hz.branch_taken_e = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (ctlNow() !== C_FREEZE) begin
        errors++; $display("FAIL brr_freeze_%0d: got %b want %b", k, ctlNow(), C_FREEZE);
      end
      tick();
    end
    hz.dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctlNow() !== C_BR) begin
      errors++; $display("FAIL brr_release: got %b want %b", ctlNow(), C_BR);
    end
    tick();
    hz.branch_taken_e = 1'b0;
  endtask

  task automatic test_saturation();
    loadToMem();
    hz.dmem_ready = 1'b0;
    repeat (15) tick();
    checks++;
    if (hz.stall_cycles !== 4'hF) begin
      errors++; $display("FAIL sat_reach: got %0d want 15", hz.stall_cycles);
    end
    repeat (2) tick();
    checks++;
    if (hz.stall_cycles !== 4'hF) begin
      errors++; $display("FAIL sat_hold: got %0d want 15", hz.stall_cycles);
    end
    hz.dmem_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clrId();
    hz.branch_taken_e = 1'b0;
    hz.dmem_ready = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_branch_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_branch_release();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Generates the stall, flush and forwarding controls consumed by the five-stage pipeline fences (PC, ID, EX, MEM, WB): StallIF, StallID, FlushD, FlushE, StallE, StallM, FlushW.
- Keeps a registered shadow of destination, source and memory-access fields for the EX, MEM and WB stages, advanced by its own control outputs.
- Covers load-use hazards, taken-branch redirects and a multi-cycle data-memory wait handshake with timeout detection.

## Interface
Parameters:
- MEM_TIMEOUT, 255: MEM-stage wait cycles after which mem_timeout asserts (1..255).
- PERF_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- rs1_d, rs2_d  in  5  source registers of the instruction in ID.
- rs1_used_d, rs2_used_d  in  1  the ID instruction reads rs1/rs2.
- rd_d  in  5  destination register of the ID instruction.
- reg_write_d  in  1  the ID instruction writes rd.
- mem_read_d, mem_write_d  in  1  the ID instruction is a load / store.
- branch_taken_e  in  1  the EX instruction redirects the PC.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- StallIF, StallID  out  1  hold the PC / ID fences.
- FlushD, FlushE  out  1  load a bubble into the ID / EX fences.
- StallE, StallM  out  1  hold the EX / MEM fences.
- FlushW  out  1  load a bubble into the WB fence.
- ForwardAE, ForwardBE  out  2  EX operand source: 00 register file, 01 WB result, 10 MEM result.
- mem_timeout  out  1  sticky; the MEM wait reached MEM_TIMEOUT cycles.
- stall_cycles  out  PERF_W  saturating count of cycles with StallIF=1.

## Operation
- Shadow registers per stage:
  - EX: rd, we, mrd, mwr, rs1, rs2.
  - MEM: rd, we, macc (mrd|mwr).
  - WB: rd, we.
- FSM has two states, RUN and MWAIT.
- In RUN, priority order:
  1. Memory stall: mem_macc & !dmem_ready. Assert StallIF, StallID, StallE, StallM and FlushW; enter MWAIT; no other action.
  2. Branch: branch_taken_e. FlushD=1, FlushE=1, no stalls. A simultaneous load-use is discarded.
  3. Load-use: ex_mrd & ex_rd!=0 & ((rs1_used_d & rs1_d==ex_rd) | (rs2_used_d & rs2_d==ex_rd)). StallIF=1, StallID=1, FlushE=1.
  4. Otherwise all controls are 0.
- In MWAIT:
  - Same freeze outputs as the memory stall in RUN while dmem_ready=0.
  - On dmem_ready=1: the freeze deasserts that cycle and the RUN rules 2–4 apply combinationally in the same cycle; next state is RUN.
- Shadow update each posedge:
  - Frozen (StallM=1): EX and MEM hold; WB clears to we=0.
  - Otherwise: WB<=MEM; MEM<=EX.
  - EX <= 0 if FlushE, else the ID-stage fields.
  - A branch-flushed ID instruction never reaches the EX shadow.
- Forwarding (combinational from shadows), per operand, using ex_rs1 for ForwardAE and ex_rs2 for ForwardBE:
  - 10 if mem_we & mem_rd!=0 & mem_rd==src.
  - else 01 if wb_we & wb_rd!=0 & wb_rd==src.
  - else 00.
  - MEM has priority over WB.
- Timeout:
  - An 8-bit wait counter clears on entering MWAIT and increments each MWAIT cycle.
  - When it equals MEM_TIMEOUT, mem_timeout sets and stays set until reset.
  - The wait continues regardless of the timeout.
- stall_cycles increments each cycle StallIF=1 and saturates at all-ones.

## Timing
- While rst_n=0 at a clock edge:
  - All shadows clear, FSM goes to RUN, the wait counter, mem_timeout and stall_cycles clear.
  - Outputs during reset: FlushD=1, FlushE=1, all others 0.
- Reset asserted mid-MWAIT aborts the wait on that edge.
- All control outputs are combinational from registered state plus same-cycle inputs; zero-cycle latency to the fences.
- Load-use costs exactly 1 bubble. A taken branch costs 2 bubbles.
- A memory stall of N cycles with dmem_ready low holds all fences N cycles.
- A branch held in EX during MWAIT takes effect in the release cycle.
- rd=0 never triggers load-use or forwarding.

## Test plan
- Load-use:
  - Stimulus: EX holds lw x5 (ex_rd=5, mrd=1); ID instruction has rs1_d=5, rs1_used_d=1.
  - Required: StallIF=StallID=FlushE=1 for 1 cycle; next cycle ForwardAE=01 (load now in WB).
- Forward priority:
  - Stimulus: add x3 followed by two instructions writing x3, with a consumer of x3 in EX.
  - Required: ForwardAE=10; with only the older write in flight, ForwardAE=01; with the destination x0, ForwardAE=00.
- Branch vs load-use in the same cycle:
  - Stimulus: branch_taken_e=1 together with the load-use condition.
  - Required: FlushD=FlushE=1, StallIF=0; the EX shadow is empty next cycle.
- Memory wait:
  - Stimulus: load in MEM, dmem_ready=0 for 3 cycles then 1.
  - Required: freeze outputs exactly 3 cycles, FlushW=1 for those 3 cycles, stall_cycles=3; mem_timeout stays 0.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dmem_ready held low 6 cycles.
  - Required: mem_timeout rises on wait cycle 4, stays 1 after release, and clears only on reset.
- Reset mid-wait:
  - Stimulus: rst_n=0 in MWAIT.
  - Required: next cycle all stalls 0, FlushD=FlushE=1, counters 0.
